// File: rtl/ex_operand_stage.sv
// ---------------------------------------------------------------------------
// ex_operand_stage
//
// ID/EX pipeline register of the RISC-V core, sitting directly in front of
// the ALU. It captures the decoded operands and control from ID, then
// resolves MEM/WB forwarding and immediate selection combinationally to
// produce the ALU's SrcA, SrcB and Operation. It also detects load-use
// hazards (requesting a one-cycle stall and loading a bubble) and converts
// the incoming instruction into a bubble on a branch flush.
//
// Ports
//   clk, reset                 clock (rising edge), async active-high reset
//   id_*                       decoded instruction presented by ID
//   flush                      discard the instruction entering EX this cycle
//   mem_rd_addr/_reg_write/_result   EX/MEM forwarding source
//   wb_rd_addr/_reg_write/_result    MEM/WB forwarding source
//   SrcA, SrcB, Operation      ALU inputs
//   ex_store_data              forwarded rs2 value for stores
//   ex_rd_addr, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write
//                              registered control travelling to MEM
//   stall                      hold PC and IF/ID this cycle
//
// Pipeline flow: id_valid marks a real instruction in ID. The instruction
// advances into EX on every rising edge unless stall is high (then a bubble
// enters EX and ID must re-present the same instruction next cycle) or flush
// is high (then a bubble enters EX and the ID instruction is dropped).
// ex_valid marks a real instruction in EX.
// ---------------------------------------------------------------------------
module ex_operand_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR      = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic [REG_ADDR-1:0]      id_rs1_addr,
  input  logic [REG_ADDR-1:0]      id_rs2_addr,
  input  logic [REG_ADDR-1:0]      id_rd_addr,
  input  logic                     id_use_rs1,
  input  logic                     id_use_rs2,
  input  logic                     id_alu_src,
  input  logic [OPCODE_LENGTH-1:0] id_alu_op,
  input  logic                     id_mem_read,
  input  logic                     id_mem_write,
  input  logic                     id_reg_write,
  input  logic                     flush,
  input  logic [REG_ADDR-1:0]      mem_rd_addr,
  input  logic                     mem_reg_write,
  input  logic [DATA_WIDTH-1:0]    mem_result,
  input  logic [REG_ADDR-1:0]      wb_rd_addr,
  input  logic                     wb_reg_write,
  input  logic [DATA_WIDTH-1:0]    wb_result,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    ex_store_data,
  output logic [REG_ADDR-1:0]      ex_rd_addr,
  output logic                     ex_valid,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write,
  output logic                     stall
);

  // ID/EX pipeline registers
  logic                     r_valid;
  logic [DATA_WIDTH-1:0]    r_rs1_data;
  logic [DATA_WIDTH-1:0]    r_rs2_data;
  logic [DATA_WIDTH-1:0]    r_imm;
  logic [REG_ADDR-1:0]      r_rs1_addr;
  logic [REG_ADDR-1:0]      r_rs2_addr;
  logic [REG_ADDR-1:0]      r_rd_addr;
  logic                     r_alu_src;
  logic [OPCODE_LENGTH-1:0] r_alu_op;
  logic                     r_mem_read;
  logic                     r_mem_write;
  logic                     r_reg_write;

  logic                     w_load_in_ex;
  logic                     w_rs1_dep;
  logic                     w_rs2_dep;
  logic                     w_stall;
  logic                     w_bubble;
  logic                     w_mem_hit_a;
  logic                     w_wb_hit_a;
  logic                     w_mem_hit_b;
  logic                     w_wb_hit_b;
  logic [DATA_WIDTH-1:0]    w_fwd_a;
  logic [DATA_WIDTH-1:0]    w_fwd_b;

  // Load-use hazard: a load writing a non-zero register sits in EX and the
  // ID instruction actually reads that register. Its data only exists after
  // MEM, so the consumer must wait one cycle and pick it up from WB.
  // Because the cycle after a stall always holds a bubble in EX, the same ID
  // instruction can never be stalled twice in a row.
  assign w_load_in_ex = r_valid & r_mem_read & (r_rd_addr != '0);
  assign w_rs1_dep    = id_use_rs1 & (id_rs1_addr == r_rd_addr);
  assign w_rs2_dep    = id_use_rs2 & (id_rs2_addr == r_rd_addr);
  assign w_stall      = w_load_in_ex & id_valid & (w_rs1_dep | w_rs2_dep) & ~flush;
  assign w_bubble     = flush | w_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_rs1_addr  <= '0;
      r_rs2_addr  <= '0;
      r_rd_addr   <= '0;
      r_alu_src   <= 1'b0;
      r_alu_op    <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_reg_write <= 1'b0;
    end else if (w_bubble) begin
      // Fully zeroed bubble: zero addresses keep it from ever matching a
      // forwarding source, and Operation presents 0.
      r_valid     <= 1'b0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_rs1_addr  <= '0;
      r_rs2_addr  <= '0;
      r_rd_addr   <= '0;
      r_alu_src   <= 1'b0;
      r_alu_op    <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_reg_write <= 1'b0;
    end else begin
      r_valid     <= id_valid;
      r_rs1_data  <= id_rs1_data;
      r_rs2_data  <= id_rs2_data;
      r_imm       <= id_imm;
      r_rs1_addr  <= id_rs1_addr;
      r_rs2_addr  <= id_rs2_addr;
      r_rd_addr   <= id_rd_addr;
      // An empty ID slot must not carry stray control into the pipeline.
      r_alu_src   <= id_valid & id_alu_src;
      r_alu_op    <= id_valid ? id_alu_op : '0;
      r_mem_read  <= id_valid & id_mem_read;
      r_mem_write <= id_valid & id_mem_write;
      r_reg_write <= id_valid & id_reg_write;
    end
  end

  // Forwarding: MEM holds the younger result, so it beats WB. x0 is never
  // forwarded because writes to it are discarded by the register file.
  assign w_mem_hit_a = mem_reg_write & (mem_rd_addr != '0) & (mem_rd_addr == r_rs1_addr);
  assign w_wb_hit_a  = wb_reg_write  & (wb_rd_addr  != '0) & (wb_rd_addr  == r_rs1_addr);
  assign w_mem_hit_b = mem_reg_write & (mem_rd_addr != '0) & (mem_rd_addr == r_rs2_addr);
  assign w_wb_hit_b  = wb_reg_write  & (wb_rd_addr  != '0) & (wb_rd_addr  == r_rs2_addr);

  assign w_fwd_a = w_mem_hit_a ? mem_result :
                   w_wb_hit_a  ? wb_result  : r_rs1_data;
  assign w_fwd_b = w_mem_hit_b ? mem_result :
                   w_wb_hit_b  ? wb_result  : r_rs2_data;

  assign SrcA          = w_fwd_a;
  assign SrcB          = r_alu_src ? r_imm : w_fwd_b;
  assign ex_store_data = w_fwd_b;
  assign Operation     = r_alu_op;
  assign ex_rd_addr    = r_rd_addr;
  assign ex_valid      = r_valid;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign stall         = w_stall;

endmodule

// File: tb/tb_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_operand_stage
//
// Directed bench for ex_operand_stage. A behavioural model tracks which
// instruction occupies EX and derives every output from the pipeline rules
// (newest in-flight writer of a register wins, bubbles carry nothing);
// a compare process checks the DUT against it on every falling edge.
// Directed scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_ex_operand_stage;

  localparam int DW = 32;
  localparam int OW = 4;
  localparam int AW = 5;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DUT signals
  logic          id_valid;
  logic [DW-1:0] id_rs1_data, id_rs2_data, id_imm;
  logic [AW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic          id_use_rs1, id_use_rs2, id_alu_src;
  logic [OW-1:0] id_alu_op;
  logic          id_mem_read, id_mem_write, id_reg_write;
  logic          flush;
  logic [AW-1:0] mem_rd_addr, wb_rd_addr;
  logic          mem_reg_write, wb_reg_write;
  logic [DW-1:0] mem_result, wb_result;
  logic [DW-1:0] SrcA, SrcB, ex_store_data;
  logic [OW-1:0] Operation;
  logic [AW-1:0] ex_rd_addr;
  logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, stall;

  ex_operand_stage #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .REG_ADDR(AW)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rd_addr(id_rd_addr), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_alu_src(id_alu_src), .id_alu_op(id_alu_op), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_reg_write(id_reg_write), .flush(flush),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .ex_store_data(ex_store_data),
    .ex_rd_addr(ex_rd_addr), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .stall(stall)
  );

  // scoreboard bookkeeping
  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // hand-computed literal: queued when stated, popped when checked
  task automatic lit(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    exp_q.push_back(exp);
    chk(name, act, exp_q.pop_front());
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model: the instruction currently occupying EX
  // ---------------------------------------------------------------------
  typedef struct packed {
    logic          valid;
    logic [DW-1:0] rs1_d, rs2_d, imm;
    logic [AW-1:0] rs1_a, rs2_a, rd;
    logic          alu_src;
    logic [OW-1:0] op;
    logic          mr, mw, rw;
  } slot_t;

  slot_t m_ex;
  logic  m_stall_at_edge;

  // Does the ID instruction need a value still being loaded by EX?
  function automatic logic model_stall();
    logic reads_load;
    reads_load = (id_use_rs1 && id_rs1_addr == m_ex.rd) ||
                 (id_use_rs2 && id_rs2_addr == m_ex.rd);
    return m_ex.valid && m_ex.mr && m_ex.rd != 0 && id_valid && reads_load && !flush;
  endfunction

  // Value of register a as seen by EX: the youngest in-flight writer wins.
  function automatic logic [DW-1:0] model_operand(input logic [AW-1:0] a, input logic [DW-1:0] rf);
    if (a == 0) return rf;
    if (mem_reg_write && mem_rd_addr == a) return mem_result;
    if (wb_reg_write && wb_rd_addr == a) return wb_result;
    return rf;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ex = '0;
    end else begin
      m_stall_at_edge = model_stall();
      if (flush || m_stall_at_edge) begin
        m_ex = '0;
      end else begin
        m_ex.valid = id_valid;
        m_ex.rs1_d = id_rs1_data;
        m_ex.rs2_d = id_rs2_data;
        m_ex.imm   = id_imm;
        m_ex.rs1_a = id_rs1_addr;
        m_ex.rs2_a = id_rs2_addr;
        m_ex.rd    = id_rd_addr;
        m_ex.alu_src = id_valid && id_alu_src;
        m_ex.op    = id_valid ? id_alu_op : '0;
        m_ex.mr    = id_valid && id_mem_read;
        m_ex.mw    = id_valid && id_mem_write;
        m_ex.rw    = id_valid && id_reg_write;
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    if (!reset) begin
      chk("ex_valid",     {31'b0, ex_valid},     {31'b0, m_ex.valid});
      chk("Operation",    {28'b0, Operation},    {28'b0, m_ex.op});
      chk("ex_rd_addr",   {27'b0, ex_rd_addr},   {27'b0, m_ex.rd});
      chk("ex_reg_write", {31'b0, ex_reg_write}, {31'b0, m_ex.rw});
      chk("ex_mem_read",  {31'b0, ex_mem_read},  {31'b0, m_ex.mr});
      chk("ex_mem_write", {31'b0, ex_mem_write}, {31'b0, m_ex.mw});
      chk("stall",        {31'b0, stall},        {31'b0, model_stall()});
      if (m_ex.valid) begin
        chk("SrcA", SrcA, model_operand(m_ex.rs1_a, m_ex.rs1_d));
        chk("ex_store_data", ex_store_data, model_operand(m_ex.rs2_a, m_ex.rs2_d));
        chk("SrcB", SrcB, m_ex.alu_src ? m_ex.imm : model_operand(m_ex.rs2_a, m_ex.rs2_d));
      end
    end
  end

  // ---------------------------------------------------------------------
  // driver tasks
  // ---------------------------------------------------------------------
  task automatic set_id(input logic v,
                        input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic [AW-1:0] a2, input logic [DW-1:0] d2,
                        input logic [AW-1:0] rd, input logic u1, input logic u2,
                        input logic src, input logic [DW-1:0] imm, input logic [OW-1:0] op,
                        input logic mr, input logic mw, input logic rw);
    id_valid = v;  id_rs1_addr = a1; id_rs1_data = d1;
    id_rs2_addr = a2; id_rs2_data = d2; id_rd_addr = rd;
    id_use_rs1 = u1; id_use_rs2 = u2; id_alu_src = src; id_imm = imm;
    id_alu_op = op; id_mem_read = mr; id_mem_write = mw; id_reg_write = rw;
  endtask

  task automatic idle_id();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
  endtask

  task automatic set_fwd(input logic mwe, input logic [AW-1:0] mrd, input logic [DW-1:0] mres,
                         input logic wwe, input logic [AW-1:0] wrd, input logic [DW-1:0] wres);
    mem_reg_write = mwe; mem_rd_addr = mrd; mem_result = mres;
    wb_reg_write  = wwe; wb_rd_addr  = wrd; wb_result  = wres;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // LW x4, 8(x1)
  task automatic id_lw4();
    set_id(1, 5'd1, 32'd100, 5'd0, 32'd0, 5'd4, 1, 0, 1, 32'd8, 4'b0010, 1, 0, 1);
  endtask

  // ---------------------------------------------------------------------
  // stimulus
  // ---------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    flush = 1'b0;
    idle_id();
    set_fwd(0, 0, 0, 0, 0, 0);
    #3;
    lit("rst_SrcA", SrcA, 32'h0);
    lit("rst_SrcB", SrcB, 32'h0);
    lit("rst_Operation", {28'b0, Operation}, 32'h0);
    lit("rst_ex_valid", {31'b0, ex_valid}, 32'h0);
    lit("rst_stall", {31'b0, stall}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // ADD x3,x1,x2 with x1=5, x2=7
    set_id(1, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 1, 1, 0, 32'd0, 4'b0010, 0, 0, 1);
    next_cycle();
    @(negedge clk);
    lit("add_SrcA", SrcA, 32'd5);
    lit("add_SrcB", SrcB, 32'd7);
    lit("add_Operation", {28'b0, Operation}, 32'h2);
    lit("add_rd", {27'b0, ex_rd_addr}, 32'd3);
    lit("add_reg_write", {31'b0, ex_reg_write}, 32'd1);

    // same ADD again, now MEM and WB both write x1: MEM must win
    next_cycle();
    set_fwd(1, 5'd1, 32'hAA, 1, 5'd1, 32'hBB);
    // next: instruction reading x0 while MEM/WB "write" x0
    set_id(1, 5'd0, 32'd0, 5'd2, 32'd7, 5'd7, 1, 1, 0, 32'd0, 4'b0000, 0, 0, 1);
    @(negedge clk);
    lit("fwd_mem_over_wb", SrcA, 32'hAA);
    lit("fwd_no_hit_rs2", SrcB, 32'd7);

    next_cycle();
    set_fwd(1, 5'd0, 32'hAA, 1, 5'd0, 32'hBB);
    // next: WB-only forwarding onto rs2
    set_id(1, 5'd3, 32'd1, 5'd2, 32'd7, 5'd8, 1, 1, 0, 32'd0, 4'b0001, 0, 0, 1);
    @(negedge clk);
    lit("x0_not_forwarded", SrcA, 32'h0);

    next_cycle();
    set_fwd(1, 5'd9, 32'h11, 1, 5'd2, 32'hBB);
    id_lw4();
    @(negedge clk);
    lit("fwd_wb_rs2", SrcB, 32'hBB);

    // load-use: LW x4 in EX, ADD x5,x1,x4 in ID
    next_cycle();
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 5'd1, 32'd5, 5'd4, 32'd0, 5'd5, 1, 1, 0, 32'd0, 4'b0010, 0, 0, 1);
    @(negedge clk);
    lit("loaduse_stall", {31'b0, stall}, 32'd1);

    next_cycle();                       // bubble in EX, load in MEM, ADD re-presented
    set_fwd(1, 5'd4, 32'h0, 0, 0, 0);
    @(negedge clk);
    lit("bubble_stall_low", {31'b0, stall}, 32'd0);
    lit("bubble_valid", {31'b0, ex_valid}, 32'd0);
    lit("bubble_op", {28'b0, Operation}, 32'h0);

    next_cycle();                       // ADD in EX, load now in WB
    set_fwd(0, 0, 0, 1, 5'd4, 32'h1234);
    id_lw4();
    @(negedge clk);
    lit("loaduse_SrcB_from_wb", SrcB, 32'h1234);
    lit("loaduse_SrcA", SrcA, 32'd5);

    // load-use coinciding with flush: flush wins
    next_cycle();                       // LW x4 in EX
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 5'd1, 32'd5, 5'd4, 32'd0, 5'd5, 1, 1, 0, 32'd0, 4'b0010, 0, 0, 1);
    flush = 1'b1;
    @(negedge clk);
    lit("flush_kills_stall", {31'b0, stall}, 32'd0);
    next_cycle();
    flush = 1'b0;
    id_lw4();
    @(negedge clk);
    lit("flush_bubble", {31'b0, ex_valid}, 32'd0);

    // ADDI x6,x1,3 with rs2 field = 4 but rs2 unused: no stall
    next_cycle();                       // LW x4 in EX
    set_id(1, 5'd1, 32'd5, 5'd4, 32'd0, 5'd6, 1, 0, 1, 32'd3, 4'b0010, 0, 0, 1);
    @(negedge clk);
    lit("addi_no_stall", {31'b0, stall}, 32'd0);

    // next: SW-like op with imm=-4 reading x6 as rs2
    next_cycle();                       // ADDI in EX
    set_id(1, 5'd1, 32'd5, 5'd6, 32'h77, 5'd0, 1, 1, 1, 32'hFFFF_FFFC, 4'b0010, 0, 1, 0);
    @(negedge clk);
    lit("addi_entered", {27'b0, ex_rd_addr}, 32'd6);

    next_cycle();
    set_fwd(1, 5'd6, 32'hCAFE, 0, 0, 0);
    id_lw4();
    @(negedge clk);
    lit("imm_SrcB", SrcB, 32'hFFFF_FFFC);
    lit("store_data_fwd", ex_store_data, 32'hCAFE);

    // back-to-back dependent loads: LW x4; LW x5,0(x4); ADD x7,x5,x5
    next_cycle();                       // LW x4 in EX
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 5'd4, 32'd0, 5'd0, 32'd0, 5'd5, 1, 0, 1, 32'd0, 4'b0010, 1, 0, 1);
    @(negedge clk);
    lit("b2b_stall1", {31'b0, stall}, 32'd1);
    next_cycle();                       // bubble
    @(negedge clk);
    lit("b2b_no_double_stall", {31'b0, stall}, 32'd0);
    next_cycle();                       // LW x5 in EX
    set_fwd(0, 0, 0, 1, 5'd4, 32'h40);
    set_id(1, 5'd5, 32'd0, 5'd5, 32'd0, 5'd7, 1, 1, 0, 32'd0, 4'b0010, 0, 0, 1);
    @(negedge clk);
    lit("b2b_lw_addr_fwd", SrcA, 32'h40);
    lit("b2b_stall2", {31'b0, stall}, 32'd1);
    next_cycle();
    set_fwd(1, 5'd5, 32'h0, 0, 0, 0);
    @(negedge clk);
    lit("b2b_stall2_once", {31'b0, stall}, 32'd0);
    next_cycle();                       // ADD in EX, LW x5 in WB
    set_fwd(0, 0, 0, 1, 5'd5, 32'h55);
    idle_id();
    @(negedge clk);
    lit("b2b_add_SrcA", SrcA, 32'h55);

    // randomised directed traffic on a small register set, model checked
    for (int i = 0; i < 80; i++) begin
      next_cycle();
      set_id($urandom_range(0, 3) != 0,
             5'($urandom_range(0, 5)), $urandom, 5'($urandom_range(0, 5)), $urandom,
             5'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      set_fwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 5)), $urandom,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 5)), $urandom);
      flush = ($urandom_range(0, 7) == 0);
    end

    // reset asserted mid-stall
    next_cycle();
    flush = 1'b0;
    set_fwd(0, 0, 0, 0, 0, 0);
    id_lw4();
    next_cycle();                       // LW x4 (op 0010) in EX
    set_id(1, 5'd4, 32'd0, 5'd0, 32'd0, 5'd5, 1, 0, 0, 32'd0, 4'b0010, 0, 0, 1);
    #1;
    lit("pre_reset_stall", {31'b0, stall}, 32'd1);
    lit("pre_reset_op", {28'b0, Operation}, 32'h2);
    reset = 1'b1;
    #1;
    lit("async_rst_stall", {31'b0, stall}, 32'd0);
    lit("async_rst_valid", {31'b0, ex_valid}, 32'd0);
    lit("async_rst_op", {28'b0, Operation}, 32'h0);
    lit("async_rst_SrcA", SrcA, 32'h0);
    lit("async_rst_SrcB", SrcB, 32'h0);
    idle_id();
    @(posedge clk);
    #1 reset = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    lit("post_reset_idle", {31'b0, ex_valid}, 32'd0);

    next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
